// File: rtl/fp32_round_pack_if.sv
// rtl/fp32_round_pack_if.sv - valid/ready bus between normalizer, round/pack stage and consumer
interface fp32_round_pack_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [23:0]      in_mant;
    logic [4:0]       in_sa;
    logic             in_rnd;
    logic             in_stk;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_ovf;
    logic             out_unf;
    logic             out_inx;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_sa, in_rnd, in_stk, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf, out_inx
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_sa, in_rnd, in_stk, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf, out_inx
    );
endinterface

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - two-stage round-to-nearest-even and IEEE-754 single pack (FP32_SAT_ON_OVF_EN: saturate on overflow)
module fp32_round_pack #(
    parameter int EXP_W   = 10,
    parameter int EXP_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp32_round_pack_if.slave      bus,
    input  logic                  clr_flags,
    output logic [2:0]            flags
);
    localparam logic signed [EXP_W:0] EXP_MAX_S = (EXP_W+1)'(EXP_MAX);

`ifdef FP32_SAT_ON_OVF_EN
    localparam logic [30:0] OVF_MAG = {8'hFE, 23'h7FFFFF};
`else
    localparam logic [30:0] OVF_MAG = {8'hFF, 23'h000000};
`endif

    logic                    s1_valid;
    logic                    s1_sign;
    logic                    s1_zero;
    logic signed [EXP_W:0]   s1_e1;
    logic [24:0]             s1_m1;
    logic                    s1_inx;
    logic                    s2_valid;

    logic                    s1_move;
    logic                    in_fire;
    logic                    out_fire;

    assign s1_move      = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s1_move;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign out_fire     = s2_valid & bus.out_ready;

    logic signed [EXP_W:0]   e1_next;
    logic                    inc_next;
    logic [24:0]             m1_next;

    assign e1_next  = $signed({bus.in_exp[EXP_W-1], bus.in_exp})
                    - $signed({{(EXP_W-4){1'b0}}, bus.in_sa});
    assign inc_next = bus.in_rnd & (bus.in_stk | bus.in_mant[0]);
    assign m1_next  = {1'b0, bus.in_mant} + {24'b0, inc_next};

    // A rounding carry out of bit 23 renormalizes by one position.
    logic [22:0]             frac2;
    logic signed [EXP_W:0]   e2;
    logic [31:0]             d2;
    logic                    ovf2;
    logic                    unf2;
    logic                    inx2;

    assign frac2 = s1_m1[24] ? s1_m1[23:1] : s1_m1[22:0];
    assign e2    = s1_e1 + $signed({{EXP_W{1'b0}}, s1_m1[24]});

    always_comb begin
        d2   = {s1_sign, e2[7:0], frac2};
        ovf2 = 1'b0;
        unf2 = 1'b0;
        inx2 = s1_inx;
        if (s1_zero) begin
            d2   = {s1_sign, 31'b0};
            inx2 = 1'b0;
        end else if (e2 >= EXP_MAX_S) begin
            d2   = {s1_sign, OVF_MAG};
            ovf2 = 1'b1;
            inx2 = 1'b1;
        end else if (e2[EXP_W] || (e2 == '0)) begin
            d2   = {s1_sign, 31'b0};
            unf2 = 1'b1;
            inx2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_zero      <= 1'b0;
            s1_e1        <= '0;
            s1_m1        <= '0;
            s1_inx       <= 1'b0;
            s2_valid     <= 1'b0;
            bus.out_data <= '0;
            bus.out_ovf  <= 1'b0;
            bus.out_unf  <= 1'b0;
            bus.out_inx  <= 1'b0;
            flags        <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                s1_sign <= bus.in_sign;
                s1_zero <= (bus.in_mant == 24'd0);
                s1_e1   <= e1_next;
                s1_m1   <= m1_next;
                s1_inx  <= bus.in_rnd | bus.in_stk;
            end
            if (s1_move) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_data <= d2;
                    bus.out_ovf  <= ovf2;
                    bus.out_unf  <= unf2;
                    bus.out_inx  <= inx2;
                end
            end
            // Clear has priority so a beat leaving in the clear cycle is not recorded.
            if (clr_flags) begin
                flags <= '0;
            end else if (out_fire) begin
                flags <= flags | {bus.out_ovf, bus.out_unf, bus.out_inx};
            end
        end
    end
endmodule

// File: tb/tb_fp32_round_pack.sv
// tb/tb_fp32_round_pack.sv - randomized and directed self-checking bench for fp32_round_pack
module tb_fp32_round_pack;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_flags = 1'b0;
    logic [2:0] flags;

    int vectors = 0;
    int errors  = 0;

    fp32_round_pack_if #(.EXP_W(10)) ifc();

    fp32_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .clr_flags (clr_flags),
        .flags     (flags)
    );

    always #5 clk = ~clk;

`ifdef FP32_SAT_ON_OVF_EN
    localparam logic [30:0] OVF_MAG = 31'h7F7FFFFF;
`else
    localparam logic [30:0] OVF_MAG = 31'h7F800000;
`endif

    typedef struct {
        logic [31:0] d;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          t;
    } exp_t;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;
        logic [4:0]  sa;
        logic        r;
        logic        k;
        logic [31:0] d;
        logic [2:0]  f;
    } dv_t;

    logic [2:0] model_flags;

    // Value-level reference: exponent minus shift, integer mantissa rounded half-to-even.
    function automatic exp_t ref_pack(input logic s, input logic [9:0] ex, input logic [23:0] m,
                                      input logic [4:0] sa, input logic r, input logic k);
        exp_t o;
        int   e;
        int   q;
        o.d = {s, 31'b0}; o.ovf = 1'b0; o.unf = 1'b0; o.inx = 1'b0; o.t = 0;
        if (m == 24'd0) return o;
        e = int'($signed(ex)) - int'(sa);
        q = int'(m);
        if (r && (k || (q % 2 == 1))) q = q + 1;
        if (q >= (1 << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        o.inx = r | k;
        if (e >= 255) begin
            o.d = {s, OVF_MAG}; o.ovf = 1'b1; o.inx = 1'b1;
        end else if (e <= 0) begin
            o.d = {s, 31'b0}; o.unf = 1'b1; o.inx = 1'b1;
        end else begin
            o.d = {s, 8'(e), 23'(q)};
        end
        return o;
    endfunction

    task automatic drive_idle();
        ifc.in_valid = 1'b0; ifc.in_sign = 1'b0; ifc.in_exp = '0; ifc.in_mant = '0;
        ifc.in_sa = '0; ifc.in_rnd = 1'b0; ifc.in_stk = 1'b0; ifc.out_ready = 1'b1;
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_flags = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 32'h0 || ifc.out_ovf !== 1'b0 ||
            ifc.out_unf !== 1'b0 || ifc.out_inx !== 1'b0 || flags !== 3'b000 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b unf=%b inx=%b flags=%b in_ready=%b, expected 0/0/0/0/0/000/1",
                     ifc.out_valid, ifc.out_data, ifc.out_ovf, ifc.out_unf, ifc.out_inx, flags, ifc.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = '0;
    endtask

    dv_t dv[11] = '{
        '{1'b0, 10'd127, 24'h800000, 5'd0,  1'b0, 1'b0, 32'h3F800000,        3'b000},
        '{1'b0, 10'd134, 24'hC00000, 5'd3,  1'b1, 1'b0, 32'h41C00000,        3'b001},
        '{1'b0, 10'd127, 24'hFFFFFF, 5'd0,  1'b1, 1'b1, 32'h40000000,        3'b001},
        '{1'b1, 10'd260, 24'h800000, 5'd2,  1'b0, 1'b0, {1'b1, OVF_MAG},     3'b101},
        '{1'b0, 10'd5,   24'h800000, 5'd10, 1'b0, 1'b0, 32'h00000000,        3'b011},
        '{1'b1, 10'd300, 24'h000000, 5'd0,  1'b0, 1'b0, 32'h80000000,        3'b000},
        '{1'b0, 10'd254, 24'h800001, 5'd0,  1'b0, 1'b0, 32'h7F000001,        3'b000},
        '{1'b0, 10'd255, 24'h800000, 5'd0,  1'b0, 1'b0, {1'b0, OVF_MAG},     3'b101},
        '{1'b0, 10'd1,   24'hA00000, 5'd0,  1'b0, 1'b1, 32'h00A00000,        3'b001},
        '{1'b1, 10'd3,   24'h800000, 5'd3,  1'b0, 1'b0, 32'h80000000,        3'b011},
        '{1'b0, 10'd254, 24'hFFFFFF, 5'd0,  1'b1, 1'b0, {1'b0, OVF_MAG},     3'b101}
    };

    task automatic test_directed();
        logic [2:0] acc;
        do_reset();
        acc = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1; ifc.in_sign = dv[i].s; ifc.in_exp = dv[i].e; ifc.in_mant = dv[i].m;
            ifc.in_sa = dv[i].sa; ifc.in_rnd = dv[i].r; ifc.in_stk = dv[i].k; ifc.out_ready = 1'b1;
            #1;
            vectors++;
            if (ifc.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready: got %b expected 1", i, ifc.in_ready);
            end
            @(negedge clk);
            ifc.in_valid = 1'b0;
            #1;
            vectors++;
            if (ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_latency1: out_valid=%b expected 0", i, ifc.out_valid);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (ifc.out_valid !== 1'b1 || ifc.out_data !== dv[i].d ||
                {ifc.out_ovf, ifc.out_unf, ifc.out_inx} !== dv[i].f) begin
                errors++;
                $display("FAIL dir%0d_result: valid=%b data=%h flags=%b expected 1 %h %b",
                         i, ifc.out_valid, ifc.out_data, {ifc.out_ovf, ifc.out_unf, ifc.out_inx}, dv[i].d, dv[i].f);
            end
            acc = acc | dv[i].f;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (flags !== acc) begin
            errors++;
            $display("FAIL dir_sticky_flags: got %b expected %b", flags, acc);
        end
    endtask

    task automatic test_flags_clear();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        vectors++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL clr_flags: got %b expected 000", flags);
        end
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1; ifc.in_sign = 1'b1; ifc.in_exp = 10'd400; ifc.in_mant = 24'h800000;
            ifc.in_sa = 5'd0; ifc.in_rnd = 1'b0; ifc.in_stk = 1'b0; ifc.out_ready = 1'b1;
            @(negedge clk);
            ifc.in_valid = 1'b0;
            @(negedge clk);
            clr_flags = (pass == 0);
            @(negedge clk);
            clr_flags = 1'b0;
            #1;
            vectors++;
            if (flags !== ((pass == 0) ? 3'b000 : 3'b101)) begin
                errors++;
                $display("FAIL clr_vs_xfer%0d: got %b expected %b", pass, flags, (pass == 0) ? 3'b000 : 3'b101);
            end
        end
    endtask

    task automatic test_stream(input int nbeats, input bit pattern);
        exp_t        q[$];
        exp_t        x;
        int          sent;
        int          c;
        bit          prev_stall;
        logic [31:0] prev_data;
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          r;
        do_reset();
        sent = 0; c = 0; prev_stall = 1'b0; prev_data = '0;
        while ((sent < nbeats || q.size() > 0) && c < 5000) begin
            @(negedge clk);
            ifc.out_ready = pattern ? pat[c % 4] : ($urandom_range(0, 3) != 0);
            clr_flags = pattern ? 1'b0 : ($urandom_range(0, 15) == 0);
            if (sent < nbeats) begin
                r = $urandom_range(0, 9);
                ifc.in_valid = pattern ? 1'b1 : ($urandom_range(0, 3) != 0);
                ifc.in_sign  = 1'($urandom);
                ifc.in_exp   = 10'($urandom_range(0, 320) - 20);
                ifc.in_mant  = (r == 0) ? 24'h0 : (r == 1) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
                ifc.in_sa    = 5'($urandom_range(0, 23));
                ifc.in_rnd   = 1'($urandom);
                ifc.in_stk   = 1'($urandom);
            end else begin
                ifc.in_valid = 1'b0;
            end
            #1;
            vectors++;
            if (ifc.in_ready !== !(q.size() == 2 && !ifc.out_ready)) begin
                errors++;
                $display("FAIL stream_in_ready c%0d: got %b expected %b", c, ifc.in_ready, !(q.size() == 2 && !ifc.out_ready));
            end
            vectors++;
            if (ifc.out_valid !== (q.size() > 0 && (c - q[0].t) >= 2)) begin
                errors++;
                $display("FAIL stream_out_valid c%0d: got %b expected %b", c, ifc.out_valid, (q.size() > 0 && (c - q[0].t) >= 2));
            end
            if (prev_stall) begin
                vectors++;
                if (ifc.out_valid !== 1'b1 || ifc.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stream_hold c%0d: valid=%b data=%h expected 1 %h", c, ifc.out_valid, ifc.out_data, prev_data);
                end
            end
            if (ifc.out_valid === 1'b1 && q.size() > 0) begin
                vectors++;
                if (ifc.out_data !== q[0].d || ifc.out_ovf !== q[0].ovf || ifc.out_unf !== q[0].unf || ifc.out_inx !== q[0].inx) begin
                    errors++;
                    $display("FAIL stream_data c%0d: got %h %b%b%b expected %h %b%b%b", c, ifc.out_data,
                             ifc.out_ovf, ifc.out_unf, ifc.out_inx, q[0].d, q[0].ovf, q[0].unf, q[0].inx);
                end
            end
            vectors++;
            if (flags !== model_flags) begin
                errors++;
                $display("FAIL stream_flags c%0d: got %b expected %b", c, flags, model_flags);
            end
            prev_stall = (ifc.out_valid === 1'b1) && !ifc.out_ready;
            prev_data  = ifc.out_data;
            if (clr_flags) begin
                model_flags = '0;
            end else if (ifc.out_valid === 1'b1 && ifc.out_ready && q.size() > 0) begin
                model_flags = model_flags | {q[0].ovf, q[0].unf, q[0].inx};
            end
            if (ifc.out_valid === 1'b1 && ifc.out_ready && q.size() > 0) void'(q.pop_front());
            if (ifc.in_valid && ifc.in_ready === 1'b1) begin
                x = ref_pack(ifc.in_sign, ifc.in_exp, ifc.in_mant, ifc.in_sa, ifc.in_rnd, ifc.in_stk);
                x.t = c;
                q.push_back(x);
                sent++;
            end
            c++;
        end
        vectors++;
        if (q.size() != 0 || sent != nbeats) begin
            errors++;
            $display("FAIL stream_drain: %0d beats pending, %0d sent, expected 0 pending %0d sent", q.size(), sent, nbeats);
        end
        @(negedge clk);
        clr_flags = 1'b0;
        ifc.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1; ifc.in_exp = 10'd127; ifc.in_mant = 24'h900000 + 24'(i);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        #1;
        vectors++;
        if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b expected 1 0", ifc.out_valid, ifc.in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || flags !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b flags=%b expected 0 1 000", ifc.out_valid, ifc.in_ready, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            vectors++;
            if (ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_discard: out_valid=%b expected 0", ifc.out_valid);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_flags = '0;
        test_reset();
        test_directed();
        test_flags_clear();
        test_stream(8, 1'b1);
        test_stream(400, 1'b0);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
